frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
Frame-level scheduler for the sprite accelerator's double-buffered frame store.
- On each display VSync, swaps the front/back buffer select (FrameBufferActive).
- Clears the new back buffer to a background colour through its own MIG write port.
- Then pulses RenderNextFrame to the sprite renderer and tracks completion through FinishedRendering.
- Counts presented and dropped frames for status/LED use.

Parameters:
- Width, 640, frame width in pixels (16 bpp).
- Height, 480, frame height in pixels.
- FrameBufferZeroStartAddress, 0, byte address of buffer 0.
- FrameBufferOneStartAddress, 614400, byte address of buffer 1.
- ClearColour, 16'h0000, background pixel; each written word is {ClearColour,ClearColour}.
- BurstWords, 16, 32-bit words per clear burst; cmd_bl = BurstWords-1.

Ports:
- Clk  in  1  system clock; the only clock.
- Rst  in  1  synchronous, active-high reset.
- calib_done  in  1  MIG calibration done; while low, block behaves as in reset.
- VSync  in  1  one-cycle pulse at start of vertical blank.
- ClearEnable  in  1  when 1, back buffer is cleared before each render.
- FrameBufferActive  out  1  0: display shows buffer 0 and render/clear target buffer 1; 1: the reverse.
- RenderNextFrame  out  1  one-cycle start pulse to the renderer.
- FinishedRendering  in  1  one-cycle done pulse from the renderer.
- FrameCount  out  16  swaps performed; wraps at 0xFFFF -> 0.
- DroppedFrames  out  16  VSyncs not honoured; saturates at 0xFFFF.
- Busy  out  1  high from the start of clear until FinishedRendering.
- write_cmd_clk, wr_clk  out  1  tied to Clk.
- write_cmd_en  out  1  MIG write command strobe.
- write_cmd_instr  out  3  constant 3'b000.
- write_cmd_bl  out  6  constant BurstWords-1.
- write_cmd_byte_addr  out  30  burst start byte address.
- write_cmd_full, write_cmd_empty  in  1  MIG command FIFO status.
- wr_en  out  1  write-data FIFO strobe.
- wr_mask  out  4  constant 4'b0000.
- wr_data  out  32  {ClearColour,ClearColour}.
- wr_full, wr_empty  in  1  write-data FIFO status.
- wr_count  in  7  write-data FIFO fill level.

Behaviour:
- Reset (Rst | ~calib_done, sampled at the Clk edge):
  - All outputs 0 except the constant ports.
  - FrameBufferActive=0, counters 0, state INIT.
- Derived constants:
  - TotalWords = Width*Height/2; TotalBursts = TotalWords/BurstWords (must divide exactly; elaboration error otherwise).
  - BurstBytes = BurstWords*4.
  - Target base = FrameBufferActive ? FrameBufferZeroStartAddress : FrameBufferOneStartAddress.
- States:
  - INIT: leave the cycle after reset deasserts -> CLEAR if ClearEnable, else START.
  - CLEAR_FILL:
    - Entry requires wr_count <= 64-BurstWords.
    - Assert wr_en for BurstWords cycles; pause (wr_en=0, word counter held) while wr_full.
    - -> CLEAR_CMD.
  - CLEAR_CMD:
    - When !write_cmd_full, assert write_cmd_en for exactly 1 cycle with addr = base + burst_idx*BurstBytes, then burst_idx++.
    - If burst_idx was TotalBursts-1 -> CLEAR_DRAIN, else -> CLEAR_FILL.
  - CLEAR_DRAIN: wait wr_empty & write_cmd_empty, so clears land before renderer writes -> START.
  - START: RenderNextFrame=1 for exactly 1 cycle -> RENDER.
  - RENDER: wait FinishedRendering -> READY.
  - READY: on VSync:
    - toggle FrameBufferActive next cycle; FrameCount++;
    - -> CLEAR if ClearEnable, else START.
- Addresses are computed at 30 bits. burst_idx is wide enough for TotalBursts (14 bits at defaults: 9600 bursts).
- VSync in any state other than READY (including INIT, CLEAR_*, START, RENDER): no swap, DroppedFrames++.
- FinishedRendering outside RENDER is ignored. FinishedRendering and VSync in the same cycle while in RENDER: go to READY; the VSync counts as dropped.
- Latency:
  - VSync in READY -> FrameBufferActive toggles 1 cycle later.
  - With ClearEnable=0, RenderNextFrame pulses 2 cycles after VSync.
- Busy = state in {CLEAR_FILL, CLEAR_CMD, CLEAR_DRAIN, START, RENDER}.
- Reset mid-clear or mid-render: abandon immediately. Already-issued MIG commands are not retracted; the renderer is expected to be reset by the same Rst.

Decomposition:
- Package frame_seq_pkg holds:
  - state encoding (INIT, CLEAR_FILL, CLEAR_CMD, CLEAR_DRAIN, START, RENDER, READY);
  - WR_FIFO_DEPTH=64;
  - MIG_CMD_WRITE=3'b000;
  - the TotalBursts/BurstBytes functions.
- One natural sub-module, frame_clear_engine: start/base in, done out, owns the MIG write port and the burst counters. The top keeps the frame FSM and the counters.

Test Plan:
- Reset/calib: hold calib_done=0, assert VSync -> all outputs 0, DroppedFrames=0. Raise calib_done with ClearEnable=1 -> first write_cmd_byte_addr=614400 with FrameBufferActive=0.
- Small clear (Width=32, Height=4, BurstWords=16) -> exactly 64 wr_en cycles with wr_data=0x00000000, wr_mask=0; 4 write_cmd_en pulses at 614400, 614464, 614528, 614592; then one RenderNextFrame pulse.
- Normal frame: FinishedRendering 100 cycles after start, then VSync -> FrameBufferActive=1 one cycle later, FrameCount=1, next clear base address 0.
- Late render: VSync during RENDER -> no toggle, DroppedFrames=1. After FinishedRendering, the next VSync swaps and FrameCount increments.
- Back-pressure:
  - write_cmd_full held 20 cycles in CLEAR_CMD -> write_cmd_en stays 0, then one pulse.
  - wr_full for 5 cycles mid-burst -> still exactly 16 wr_en cycles for that burst.
- Reset mid-clear: Rst pulsed during burst 2 -> next cycle wr_en=0, write_cmd_en=0, FrameBufferActive=0. Clear restarts at 614400 after release.

Source files
------------

// File: rtl/frame_seq_pkg.sv
// Shared types and constants for the frame sequencer.
// Holds the FSM encoding and the clear-geometry helpers.
package frame_seq_pkg;

   typedef enum logic [2:0] {
      INIT,
      CLEAR_FILL,
      CLEAR_CMD,
      CLEAR_DRAIN,
      START,
      RENDER,
      READY
   } state_t;

   localparam int unsigned WR_FIFO_DEPTH = 64;
   localparam logic [2:0]  MIG_CMD_WRITE = 3'b000;

   function automatic int unsigned total_bursts(
      input int unsigned w,
      input int unsigned h,
      input int unsigned bw
   );
      return (w * h / 2) / bw;
   endfunction

   function automatic int unsigned burst_bytes(input int unsigned bw);
      return bw * 4;
   endfunction

endpackage

// File: rtl/frame_clear_engine.sv
// Back-buffer clear engine: fills the MIG write FIFO one burst
// at a time and issues the matching write command per burst.
module frame_clear_engine
   import frame_seq_pkg::*;
#(
   parameter int unsigned TotalBursts = 9600,
   parameter int unsigned BurstWords  = 16,
   parameter logic [15:0] ClearColour = 16'h0000
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        start,
   input  logic [29:0] base,
   output logic        done,
   output state_t      phase_nxt,
   output logic        write_cmd_en,
   output logic [29:0] write_cmd_byte_addr,
   input  logic        write_cmd_full,
   input  logic        write_cmd_empty,
   output logic        wr_en,
   output logic [31:0] wr_data,
   input  logic        wr_full,
   input  logic        wr_empty,
   input  logic [6:0]  wr_count
);

   localparam int unsigned BW = $clog2(TotalBursts + 1);
   localparam int unsigned WW = $clog2(BurstWords + 1);
   localparam logic [BW-1:0] LAST_BURST = BW'(TotalBursts - 1);
   localparam logic [WW-1:0] LAST_WORD  = WW'(BurstWords - 1);
   localparam logic [6:0]  FILL_LIMIT  = 7'(WR_FIFO_DEPTH - BurstWords);
   localparam logic [29:0] BURST_BYTES = 30'(burst_bytes(BurstWords));

   state_t          phase;
   logic [BW-1:0]   burst;
   logic [WW-1:0]   word;

   assign wr_data = {ClearColour, ClearColour};

   always_comb begin
      phase_nxt           = phase;
      done                = 1'b0;
      wr_en               = 1'b0;
      write_cmd_en        = 1'b0;
      write_cmd_byte_addr = '0;
      unique case (phase)
         INIT: begin
            if (start) phase_nxt = CLEAR_FILL;
         end
         CLEAR_FILL: begin
            // room for a whole burst is only required before its first word
            wr_en = !wr_full && (word != '0 || wr_count <= FILL_LIMIT);
            if (wr_en && word == LAST_WORD) phase_nxt = CLEAR_CMD;
         end
         CLEAR_CMD: begin
            write_cmd_byte_addr = base + 30'(burst) * BURST_BYTES;
            write_cmd_en        = !write_cmd_full;
            if (write_cmd_en)
               phase_nxt = (burst == LAST_BURST) ? CLEAR_DRAIN : CLEAR_FILL;
         end
         CLEAR_DRAIN: begin
            if (wr_empty && write_cmd_empty) begin
               done      = 1'b1;
               phase_nxt = INIT;
            end
         end
         default: phase_nxt = INIT;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         phase <= INIT;
         burst <= '0;
         word  <= '0;
      end else begin
         phase <= phase_nxt;
         if (wr_en)
            word <= (word == LAST_WORD) ? '0 : word + WW'(1);
         if (write_cmd_en)
            burst <= (burst == LAST_BURST) ? '0 : burst + BW'(1);
      end
   end

endmodule

// File: rtl/frame_sequencer.sv
// Frame scheduler for the double-buffered sprite frame store:
// swaps buffers on VSync, clears the back buffer, kicks the renderer.
module frame_sequencer
   import frame_seq_pkg::*;
#(
   parameter int unsigned Width                       = 640,
   parameter int unsigned Height                      = 480,
   parameter int unsigned FrameBufferZeroStartAddress = 0,
   parameter int unsigned FrameBufferOneStartAddress  = 614400,
   parameter logic [15:0] ClearColour                 = 16'h0000,
   parameter int unsigned BurstWords                  = 16
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        calib_done,
   input  logic        VSync,
   input  logic        ClearEnable,
   output logic        FrameBufferActive,
   output logic        RenderNextFrame,
   input  logic        FinishedRendering,
   output logic [15:0] FrameCount,
   output logic [15:0] DroppedFrames,
   output logic        Busy,
   output logic        write_cmd_clk,
   output logic        wr_clk,
   output logic        write_cmd_en,
   output logic [2:0]  write_cmd_instr,
   output logic [5:0]  write_cmd_bl,
   output logic [29:0] write_cmd_byte_addr,
   input  logic        write_cmd_full,
   input  logic        write_cmd_empty,
   output logic        wr_en,
   output logic [3:0]  wr_mask,
   output logic [31:0] wr_data,
   input  logic        wr_full,
   input  logic        wr_empty,
   input  logic [6:0]  wr_count
);

   localparam int unsigned TotalWords  = Width * Height / 2;
   localparam int unsigned TotalBursts = total_bursts(Width, Height, BurstWords);
   localparam logic [29:0] BASE0 = 30'(FrameBufferZeroStartAddress);
   localparam logic [29:0] BASE1 = 30'(FrameBufferOneStartAddress);

   if ((Width * Height) % 2 != 0 || TotalWords % BurstWords != 0) begin : g_bad_geom
      $error("frame_sequencer: frame size is not a whole number of bursts");
   end

   state_t      state, state_nxt, clr_phase_nxt;
   logic        rst_int, swap, drop, clr_start, clr_done;
   logic [29:0] clr_base;

   assign rst_int         = Rst | ~calib_done;
   assign write_cmd_clk   = Clk;
   assign wr_clk          = Clk;
   assign write_cmd_instr = MIG_CMD_WRITE;
   assign write_cmd_bl    = 6'(BurstWords - 1);
   assign wr_mask         = 4'b0000;

   // the display owns FrameBufferActive; we always draw into the other one
   assign clr_base  = FrameBufferActive ? BASE0 : BASE1;
   assign swap      = (state == READY) && VSync;
   assign drop      = VSync && (state != READY);
   assign clr_start = ClearEnable && ((state == INIT) || swap);
   assign Busy      = state inside {CLEAR_FILL, CLEAR_CMD, CLEAR_DRAIN, START, RENDER};

   always_comb begin
      state_nxt = state;
      unique case (state)
         INIT:
            state_nxt = ClearEnable ? CLEAR_FILL : START;
         CLEAR_FILL, CLEAR_CMD, CLEAR_DRAIN:
            state_nxt = clr_done ? START : clr_phase_nxt;
         START:
            state_nxt = RENDER;
         RENDER:
            if (FinishedRendering) state_nxt = READY;
         READY:
            if (VSync) state_nxt = ClearEnable ? CLEAR_FILL : START;
         default:
            state_nxt = INIT;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (rst_int) begin
         state             <= INIT;
         FrameBufferActive <= 1'b0;
         RenderNextFrame   <= 1'b0;
         FrameCount        <= '0;
         DroppedFrames     <= '0;
      end else begin
         state           <= state_nxt;
         RenderNextFrame <= (state == START);
         if (swap) begin
            FrameBufferActive <= ~FrameBufferActive;
            FrameCount        <= FrameCount + 16'd1;
         end
         if (drop && DroppedFrames != 16'hFFFF)
            DroppedFrames <= DroppedFrames + 16'd1;
      end
   end

   frame_clear_engine #(
      .TotalBursts (TotalBursts),
      .BurstWords  (BurstWords),
      .ClearColour (ClearColour)
   ) u_clear (
      .Clk                 (Clk),
      .Rst                 (rst_int),
      .start               (clr_start),
      .base                (clr_base),
      .done                (clr_done),
      .phase_nxt           (clr_phase_nxt),
      .write_cmd_en        (write_cmd_en),
      .write_cmd_byte_addr (write_cmd_byte_addr),
      .write_cmd_full      (write_cmd_full),
      .write_cmd_empty     (write_cmd_empty),
      .wr_en               (wr_en),
      .wr_data             (wr_data),
      .wr_full             (wr_full),
      .wr_empty            (wr_empty),
      .wr_count            (wr_count)
   );

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer on a 32x4 frame (4 bursts of 16 words).
// A negedge monitor logs MIG traffic; tasks compare it to the frame model.
module tb_frame_sequencer;

   logic        Clk, Rst, calib_done, VSync, ClearEnable;
   logic        FrameBufferActive, RenderNextFrame, FinishedRendering;
   logic [15:0] FrameCount, DroppedFrames;
   logic        Busy, write_cmd_clk, wr_clk, write_cmd_en;
   logic [2:0]  write_cmd_instr;
   logic [5:0]  write_cmd_bl;
   logic [29:0] write_cmd_byte_addr;
   logic        write_cmd_full, write_cmd_empty, wr_en;
   logic [3:0]  wr_mask;
   logic [31:0] wr_data;
   logic        wr_full, wr_empty;
   logic [6:0]  wr_count;

   frame_sequencer #(
      .Width      (32),
      .Height     (4),
      .BurstWords (16)
   ) dut (
      .Clk                 (Clk),
      .Rst                 (Rst),
      .calib_done          (calib_done),
      .VSync               (VSync),
      .ClearEnable         (ClearEnable),
      .FrameBufferActive   (FrameBufferActive),
      .RenderNextFrame     (RenderNextFrame),
      .FinishedRendering   (FinishedRendering),
      .FrameCount          (FrameCount),
      .DroppedFrames       (DroppedFrames),
      .Busy                (Busy),
      .write_cmd_clk       (write_cmd_clk),
      .wr_clk              (wr_clk),
      .write_cmd_en        (write_cmd_en),
      .write_cmd_instr     (write_cmd_instr),
      .write_cmd_bl        (write_cmd_bl),
      .write_cmd_byte_addr (write_cmd_byte_addr),
      .write_cmd_full      (write_cmd_full),
      .write_cmd_empty     (write_cmd_empty),
      .wr_en               (wr_en),
      .wr_mask             (wr_mask),
      .wr_data             (wr_data),
      .wr_full             (wr_full),
      .wr_empty            (wr_empty),
      .wr_count            (wr_count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   // frame-level reference model
   logic        exp_fba;
   logic [15:0] exp_fc, exp_drop;
   bit          m_ready;

   // MIG traffic log
   int          wr_total, rnf_cnt, viol, data_bad, words_cur;
   logic [29:0] addr_q[$];
   int          words_q[$];

   always @(negedge Clk) begin
      if (wr_en) begin
         wr_total++;
         if (wr_full || (words_cur == 0 && wr_count > 7'd48)) viol++;
         if (wr_data !== 32'h0 || wr_mask !== 4'h0) data_bad++;
         words_cur++;
      end
      if (write_cmd_en) begin
         if (write_cmd_full) viol++;
         addr_q.push_back(write_cmd_byte_addr);
         words_q.push_back(words_cur);
         words_cur = 0;
      end
      if (RenderNextFrame) rnf_cnt++;
   end

   function automatic logic [29:0] exp_base(input logic fba);
      return fba ? 30'd0 : 30'd614400;
   endfunction

   task automatic clr_stats;
      wr_total = 0; rnf_cnt = 0; viol = 0; data_bad = 0; words_cur = 0;
      addr_q.delete();
      words_q.delete();
   endtask

   task automatic model_vsync;
      if (m_ready) begin
         exp_fba = ~exp_fba;
         exp_fc  = exp_fc + 16'd1;
         m_ready = 0;
      end else if (exp_drop != 16'hFFFF) begin
         exp_drop = exp_drop + 16'd1;
      end
   endtask

   task automatic pulse_vsync;
      @(posedge Clk); #1 VSync = 1'b1;
      @(posedge Clk); #1 VSync = 1'b0;
      model_vsync();
   endtask

   task automatic pulse_fin;
      @(posedge Clk); #1 FinishedRendering = 1'b1;
      @(posedge Clk); #1 FinishedRendering = 1'b0;
      m_ready = 1;
   endtask

   task automatic wait_rnf(input string nm, input bit rnd);
      int n = 0;
      while (rnf_cnt == 0 && n < 3000) begin
         @(posedge Clk); #1;
         if (rnd) begin
            wr_full         = ($urandom_range(3) == 0);
            write_cmd_full  = ($urandom_range(2) == 0);
            wr_count        = 7'($urandom_range(63));
            wr_empty        = ($urandom_range(1) == 0);
            write_cmd_empty = ($urandom_range(1) == 0);
         end
         @(negedge Clk); #1;
         n++;
      end
      wr_full = 0; write_cmd_full = 0; wr_count = 0;
      wr_empty = 1; write_cmd_empty = 1;
      checks++;
      if (rnf_cnt == 0) begin
         errors++;
         $display("FAIL %s_timeout: got no RenderNextFrame expected 1", nm);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge Clk);
      #1 Rst = 1'b0; VSync = 1'b1;
      @(posedge Clk); #1 VSync = 1'b0;
      repeat (2) @(negedge Clk);
      checks++;
      if ({FrameBufferActive, RenderNextFrame, Busy, wr_en, write_cmd_en} !== 5'b0) begin
         errors++;
         $display("FAIL rst_bits: got %b expected 00000",
                  {FrameBufferActive, RenderNextFrame, Busy, wr_en, write_cmd_en});
      end
      checks++;
      if (FrameCount !== 16'd0 || DroppedFrames !== 16'd0) begin
         errors++;
         $display("FAIL rst_cnt: got fc=%0d drop=%0d expected 0 0", FrameCount, DroppedFrames);
      end
      checks++;
      if (write_cmd_byte_addr !== 30'd0) begin
         errors++;
         $display("FAIL rst_addr: got %0d expected 0", write_cmd_byte_addr);
      end
      checks++;
      if (write_cmd_instr !== 3'b000 || write_cmd_bl !== 6'd15 || wr_mask !== 4'h0) begin
         errors++;
         $display("FAIL rst_const: got instr=%0d bl=%0d mask=%0h expected 0 15 0",
                  write_cmd_instr, write_cmd_bl, wr_mask);
      end
   endtask

   task automatic test_first_clear;
      clr_stats();
      ClearEnable = 1'b1;
      @(posedge Clk); #1 calib_done = 1'b1;
      wait_rnf("first_clear", 0);
      checks++;
      if (addr_q.size() != 4) begin
         errors++;
         $display("FAIL fc_ncmd: got %0d expected 4", addr_q.size());
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (addr_q[i] !== exp_base(exp_fba) + 30'(i * 64)) begin
            errors++;
            $display("FAIL fc_addr%0d: got %0d expected %0d", i, addr_q[i],
                     exp_base(exp_fba) + 30'(i * 64));
         end
         checks++;
         if (words_q[i] != 16) begin
            errors++;
            $display("FAIL fc_words%0d: got %0d expected 16", i, words_q[i]);
         end
      end
      checks++;
      if (wr_total != 64 || viol != 0 || data_bad != 0 || rnf_cnt != 1) begin
         errors++;
         $display("FAIL fc_traffic: got wr=%0d viol=%0d bad=%0d rnf=%0d expected 64 0 0 1",
                  wr_total, viol, data_bad, rnf_cnt);
      end
      checks++;
      if (Busy !== 1'b1 || FrameBufferActive !== exp_fba) begin
         errors++;
         $display("FAIL fc_state: got busy=%b fba=%b expected 1 %b",
                  Busy, FrameBufferActive, exp_fba);
      end
   endtask

   task automatic test_normal_frame;
      repeat (99) @(posedge Clk);
      #1 FinishedRendering = 1'b1;
      @(posedge Clk); #1 FinishedRendering = 1'b0;
      m_ready = 1;
      @(negedge Clk);
      checks++;
      if (Busy !== 1'b0) begin
         errors++;
         $display("FAIL nf_ready: got busy=%b expected 0", Busy);
      end
      clr_stats();
      @(posedge Clk); #1 VSync = 1'b1;
      @(negedge Clk);
      checks++;
      if (FrameBufferActive !== exp_fba) begin
         errors++;
         $display("FAIL nf_early: got fba=%b expected %b", FrameBufferActive, exp_fba);
      end
      @(posedge Clk); #1 VSync = 1'b0;
      model_vsync();
      @(negedge Clk);
      checks++;
      if (FrameBufferActive !== exp_fba || FrameCount !== exp_fc) begin
         errors++;
         $display("FAIL nf_swap: got fba=%b fc=%0d expected %b %0d",
                  FrameBufferActive, FrameCount, exp_fba, exp_fc);
      end
      wait_rnf("normal", 1);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (addr_q[i] !== exp_base(exp_fba) + 30'(i * 64) || words_q[i] != 16) begin
            errors++;
            $display("FAIL nf_burst%0d: got addr=%0d words=%0d expected %0d 16", i,
                     addr_q[i], words_q[i], exp_base(exp_fba) + 30'(i * 64));
         end
      end
      checks++;
      if (addr_q.size() != 4 || wr_total != 64 || viol != 0 || data_bad != 0) begin
         errors++;
         $display("FAIL nf_traffic: got cmds=%0d wr=%0d viol=%0d bad=%0d expected 4 64 0 0",
                  addr_q.size(), wr_total, viol, data_bad);
      end
   endtask

   task automatic test_late_render;
      pulse_vsync();
      @(negedge Clk);
      checks++;
      if (FrameBufferActive !== exp_fba || DroppedFrames !== exp_drop || FrameCount !== exp_fc) begin
         errors++;
         $display("FAIL late_drop: got fba=%b drop=%0d fc=%0d expected %b %0d %0d",
                  FrameBufferActive, DroppedFrames, FrameCount, exp_fba, exp_drop, exp_fc);
      end
      pulse_fin();
      ClearEnable = 1'b0;
      clr_stats();
      @(posedge Clk); #1 VSync = 1'b1;
      @(negedge Clk);
      checks++;
      if (RenderNextFrame !== 1'b0) begin
         errors++;
         $display("FAIL late_rnf0: got %b expected 0", RenderNextFrame);
      end
      @(posedge Clk); #1 VSync = 1'b0;
      model_vsync();
      @(negedge Clk);
      checks++;
      if (FrameBufferActive !== exp_fba || FrameCount !== exp_fc || RenderNextFrame !== 1'b0) begin
         errors++;
         $display("FAIL late_swap: got fba=%b fc=%0d rnf=%b expected %b %0d 0",
                  FrameBufferActive, FrameCount, RenderNextFrame, exp_fba, exp_fc);
      end
      @(negedge Clk);
      checks++;
      if (RenderNextFrame !== 1'b1) begin
         errors++;
         $display("FAIL late_rnf2: got %b expected 1", RenderNextFrame);
      end
      @(negedge Clk); #1;
      checks++;
      if (RenderNextFrame !== 1'b0 || wr_total != 0 || rnf_cnt != 1) begin
         errors++;
         $display("FAIL late_rnf3: got rnf=%b wr=%0d pulses=%0d expected 0 0 1",
                  RenderNextFrame, wr_total, rnf_cnt);
      end
   endtask

   task automatic test_same_cycle;
      @(posedge Clk); #1 FinishedRendering = 1'b1; VSync = 1'b1;
      @(posedge Clk); #1 FinishedRendering = 1'b0; VSync = 1'b0;
      model_vsync();
      m_ready = 1;
      @(negedge Clk);
      checks++;
      if (DroppedFrames !== exp_drop || FrameBufferActive !== exp_fba || Busy !== 1'b0) begin
         errors++;
         $display("FAIL same_drop: got drop=%0d fba=%b busy=%b expected %0d %b 0",
                  DroppedFrames, FrameBufferActive, Busy, exp_drop, exp_fba);
      end
      clr_stats();
      pulse_vsync();
      @(negedge Clk);
      checks++;
      if (FrameBufferActive !== exp_fba || FrameCount !== exp_fc) begin
         errors++;
         $display("FAIL same_swap: got fba=%b fc=%0d expected %b %0d",
                  FrameBufferActive, FrameCount, exp_fba, exp_fc);
      end
      wait_rnf("same", 0);
   endtask

   task automatic test_backpressure;
      int n;
      pulse_fin();
      ClearEnable = 1'b1;
      write_cmd_full = 1'b1;
      clr_stats();
      pulse_vsync();
      repeat (40) @(negedge Clk);
      #1;
      checks++;
      if (addr_q.size() != 0 || wr_total != 16 || write_cmd_en !== 1'b0) begin
         errors++;
         $display("FAIL bp_cmdhold: got cmds=%0d wr=%0d en=%b expected 0 16 0",
                  addr_q.size(), wr_total, write_cmd_en);
      end
      @(posedge Clk); #1 write_cmd_full = 1'b0;
      n = 0;
      while (addr_q.size() < 1 && n < 50) begin @(negedge Clk); #1; n++; end
      checks++;
      if (addr_q.size() != 1) begin
         errors++;
         $display("FAIL bp_cmdrel: got cmds=%0d expected 1", addr_q.size());
      end
      n = 0;
      while (wr_total < 20 && n < 50) begin @(negedge Clk); #1; n++; end
      wr_full = 1'b1;
      repeat (5) @(negedge Clk);
      #1;
      checks++;
      if (wr_total != 20) begin
         errors++;
         $display("FAIL bp_wrhold: got wr=%0d expected 20", wr_total);
      end
      wr_full = 1'b0;
      wait_rnf("bp", 0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (addr_q[i] !== exp_base(exp_fba) + 30'(i * 64) || words_q[i] != 16) begin
            errors++;
            $display("FAIL bp_burst%0d: got addr=%0d words=%0d expected %0d 16", i,
                     addr_q[i], words_q[i], exp_base(exp_fba) + 30'(i * 64));
         end
      end
      checks++;
      if (wr_total != 64 || viol != 0) begin
         errors++;
         $display("FAIL bp_traffic: got wr=%0d viol=%0d expected 64 0", wr_total, viol);
      end
   endtask

   task automatic test_reset_mid_clear;
      int n = 0;
      pulse_fin();
      clr_stats();
      pulse_vsync();
      while (wr_total < 37 && n < 300) begin @(negedge Clk); #1; n++; end
      @(posedge Clk); #1 Rst = 1'b1;
      @(posedge Clk); #1 Rst = 1'b0;
      exp_fba = 0; exp_fc = 0; exp_drop = 0; m_ready = 0;
      @(negedge Clk);
      checks++;
      if ({wr_en, write_cmd_en, FrameBufferActive, Busy} !== 4'b0 || FrameCount !== exp_fc) begin
         errors++;
         $display("FAIL mid_rst: got wr=%b cmd=%b fba=%b busy=%b fc=%0d expected 0 0 0 0 0",
                  wr_en, write_cmd_en, FrameBufferActive, Busy, FrameCount);
      end
      #1 clr_stats();
      wait_rnf("mid_rst", 1);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (addr_q[i] !== exp_base(exp_fba) + 30'(i * 64) || words_q[i] != 16) begin
            errors++;
            $display("FAIL mid_burst%0d: got addr=%0d words=%0d expected %0d 16", i,
                     addr_q[i], words_q[i], exp_base(exp_fba) + 30'(i * 64));
         end
      end
      checks++;
      if (addr_q.size() != 4 || wr_total != 64 || viol != 0 || DroppedFrames !== exp_drop) begin
         errors++;
         $display("FAIL mid_traffic: got cmds=%0d wr=%0d viol=%0d drop=%0d expected 4 64 0 %0d",
                  addr_q.size(), wr_total, viol, DroppedFrames, exp_drop);
      end
   endtask

   initial begin
      Rst = 1'b1; calib_done = 1'b0; VSync = 1'b0; ClearEnable = 1'b0;
      FinishedRendering = 1'b0; write_cmd_full = 1'b0; write_cmd_empty = 1'b1;
      wr_full = 1'b0; wr_empty = 1'b1; wr_count = 7'd0;
      exp_fba = 0; exp_fc = 0; exp_drop = 0; m_ready = 0;
      clr_stats();
      test_reset();
      test_first_clear();
      test_normal_frame();
      test_late_render();
      test_same_cycle();
      test_backpressure();
      test_reset_mid_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
